// File: rtl/drop_random_pkg.sv
// Shared constants and types for the falling-knife random source.
// Holds LFSR geometry, default seeds and default drop thresholds.
package drop_random_pkg;

  localparam int LFSR_W = 5;
  localparam int TAP_HI = 4;
  localparam int TAP_LO = 2;

  localparam logic [LFSR_W-1:0] LFSR_ZERO = '0;
  localparam logic [LFSR_W-1:0] SEED_ONE  = 5'h01;

  localparam logic [LFSR_W-1:0] SEED_PRN_DEF  = 5'h01;
  localparam logic [LFSR_W-1:0] SEED_DROP_DEF = 5'h15;

  localparam int EASY_TH_DEF    = 4;
  localparam int NORMAL_TH_DEF  = 10;
  localparam int EXTREME_TH_DEF = 20;

  typedef struct packed {
    logic easy;
    logic normal;
    logic extreme;
  } drop_flags_t;

  // An all-zero seed would lock the LFSR, so fall back to 1.
  function automatic logic [LFSR_W-1:0] seed_fix(
    input logic [LFSR_W-1:0] s
  );
    return (s == LFSR_ZERO) ? SEED_ONE : s;
  endfunction

endpackage

// File: rtl/drop_random_lfsr_5bit.sv
// Free-running 5-bit Fibonacci LFSR, polynomial x^5+x^3+1.
// A zero state reloads the seed on the next edge.
module lfsr_5bit
  import drop_random_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = SEED_PRN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] L_SEED = seed_fix(SEED);

  logic [LFSR_W-1:0] r_q;
  logic              w_fb;

  assign w_fb = r_q[TAP_HI] ^ r_q[TAP_LO];
  assign q    = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= L_SEED;
    end else if (r_q == LFSR_ZERO) begin
      r_q <= L_SEED;
    end else begin
      r_q <= {r_q[LFSR_W-2:0], w_fb};
    end
  end

endmodule

// File: rtl/drop_random.sv
// Column position source plus three nested, registered drop flags
// derived from an independent drop LFSR.
module drop_random
  import drop_random_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED_PRN   = SEED_PRN_DEF,
  parameter logic [LFSR_W-1:0] SEED_DROP  = SEED_DROP_DEF,
  parameter int                EASY_TH    = EASY_TH_DEF,
  parameter int                NORMAL_TH  = NORMAL_TH_DEF,
  parameter int                EXTREME_TH = EXTREME_TH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] prn,
  output logic              easy_t,
  output logic              normal_t,
  output logic              extreme_t
);

  localparam logic [LFSR_W-1:0] L_EASY    = EASY_TH[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] L_NORMAL  = NORMAL_TH[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] L_EXTREME = EXTREME_TH[LFSR_W-1:0];

  logic [LFSR_W-1:0] w_drop;
  drop_flags_t       w_flags;
  drop_flags_t       r_flags;

  lfsr_5bit #(.SEED(SEED_PRN)) u_col (
    .clk (clk),
    .rst (rst),
    .q   (prn)
  );

  lfsr_5bit #(.SEED(SEED_DROP)) u_drop (
    .clk (clk),
    .rst (rst),
    .q   (w_drop)
  );

  always_comb begin
    w_flags         = '0;
    w_flags.easy    = (w_drop < L_EASY);
    w_flags.normal  = (w_drop < L_NORMAL);
    w_flags.extreme = (w_drop < L_EXTREME);
  end

  // Flags register on the same edge that advances the drop LFSR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= '0;
    end else begin
      r_flags <= w_flags;
    end
  end

  assign easy_t    = r_flags.easy;
  assign normal_t  = r_flags.normal;
  assign extreme_t = r_flags.extreme;

endmodule

// File: tb/tb_drop_random.sv
// Scoreboard bench for drop_random: reference model, sequence tables,
// period/count checks, async reset and zero-seed override.
module tb_drop_random;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] prn, prn0;
  logic       e, n, x, e0, n0, x0;

  drop_random dut (
    .clk       (clk),
    .rst       (rst),
    .prn       (prn),
    .easy_t    (e),
    .normal_t  (n),
    .extreme_t (x)
  );

  drop_random #(.SEED_PRN(5'h00)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .prn       (prn0),
    .easy_t    (e0),
    .normal_t  (n0),
    .extreme_t (x0)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pop  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int nxt(input int q);
    return ((q << 1) & 31) | (((q >> 4) ^ (q >> 2)) & 1);
  endfunction

  function automatic int flags_of(input int d);
    return ((d < 4) ? 4 : 0) + ((d < 10) ? 2 : 0) + ((d < 20) ? 1 : 0);
  endfunction

  typedef struct {
    int p;
    int fl;
  } exp_t;

  exp_t sb[$];
  exp_t t_push;
  exp_t t_pop;
  int   m_prn  = 1;
  int   m_drop = 21;

  // Reference model: one expected output set per clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prn  = 1;
      m_drop = 21;
      sb.delete();
    end else begin
      t_push.fl = flags_of(m_drop);
      m_prn     = nxt(m_prn);
      m_drop    = nxt(m_drop);
      t_push.p  = m_prn;
      sb.push_back(t_push);
    end
  end

  always @(negedge clk) begin
    if (!rst && sb.size() > 0) begin
      t_pop = sb.pop_front();
      chk("sb_prn", {27'd0, prn}, t_pop.p);
      chk("sb_flags", {29'd0, e, n, x}, t_pop.fl);
      chk("sb_prn_seed0", {27'd0, prn0}, t_pop.p);
      n_pop++;
    end
  end

  logic [4:0] s  [32];
  logic [4:0] s0 [32];
  logic [2:0] f  [32];
  int prn_tab [7] = '{1, 2, 4, 9, 'h12, 5, 'hB};
  int fl_tab  [6] = '{0, 1, 0, 3, 1, 7};

  initial begin
    bit seen [32];
    int dup, ce, cn, cx, bad;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_prn", {27'd0, prn}, 1);
    chk("rst_flags", {29'd0, e, n, x}, 0);
    chk("rst_prn_seed0", {27'd0, prn0}, 1);

    @(negedge clk) rst = 1'b0;
    s[0]  = prn;
    s0[0] = prn0;
    f[0]  = {e, n, x};
    for (int k = 1; k < 32; k++) begin
      @(posedge clk);
      #1;
      s[k]  = prn;
      s0[k] = prn0;
      f[k]  = {e, n, x};
    end

    for (int i = 0; i < 7; i++) begin
      chk("prn_seq", {27'd0, s[i]}, prn_tab[i]);
      chk("prn_seq_seed0", {27'd0, s0[i]}, prn_tab[i]);
    end
    for (int i = 1; i < 7; i++)
      chk("flag_seq", {29'd0, f[i]}, fl_tab[i-1]);

    dup = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int i = 0; i < 31; i++) begin
      if (s[i] == 5'd0 || seen[s[i]]) dup++;
      seen[s[i]] = 1'b1;
    end
    chk("prn_unique", dup, 0);
    chk("prn_period", {27'd0, s[31]}, int'(s[0]));

    ce = 0; cn = 0; cx = 0;
    for (int i = 1; i < 32; i++) begin
      ce += int'(f[i][2]);
      cn += int'(f[i][1]);
      cx += int'(f[i][0]);
    end
    chk("cnt_easy", ce, 3);
    chk("cnt_normal", cn, 9);
    chk("cnt_extreme", cx, 19);

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if ($isunknown({e, n, x, prn})) bad++;
      else if ((e && !n) || (n && !x) || prn == 5'd0) bad++;
    end
    chk("nesting", bad, 0);

    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_prn", {27'd0, prn}, 1);
    chk("async_rst_flags", {29'd0, e, n, x}, 0);
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k < 7; k++) begin
      @(posedge clk);
      #1;
      chk("restart_prn", {27'd0, prn}, prn_tab[k]);
      chk("restart_flags", {29'd0, e, n, x}, fl_tab[k-1]);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_activity", {31'd0, n_pop > 130}, 1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
